// File: rtl/vga_scan_if.sv
// vga_scan_if: sprite inputs and raster/video outputs of the scan generator
interface vga_scan_if;
  logic       car_on;
  logic [2:0] car_rgb;
  logic [2:0] bg_rgb;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pixel_tick;
  logic       video_on;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb_out;
  modport master (
    input  car_on, car_rgb, bg_rgb,
    output pixel_x, pixel_y, pixel_tick, video_on, frame_start, hsync, vsync, rgb_out
  );
  modport slave (
    output car_on, car_rgb, bg_rgb,
    input  pixel_x, pixel_y, pixel_tick, video_on, frame_start, hsync, vsync, rgb_out
  );
endinterface

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: pixel-rate raster counters, registered syncs and composited colour
module vga_scan_generator #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic         clk,
  input logic         reset,
  vga_scan_if.master  bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  logic       tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] rgb_next;
  logic       hsync_q;
  logic       vsync_q;
  logic [2:0] rgb_q;
  // divide clk by two and advance the raster one pixel per tick, line on x wrap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tick <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        x <= (x == H_LAST) ? '0 : x + 10'd1;
        if (x == H_LAST) y <= (y == V_LAST) ? '0 : y + 10'd1;
      end
    end
  // sync windows and car-over-road compositing for the pixel currently addressed
  always_comb begin
    video    = (x < H_VIS) && (y < V_VIS);
    hs_raw   = (x >= HS_BEG) && (x < HS_END);
    vs_raw   = (y >= VS_BEG) && (y < VS_END);
    rgb_next = !video ? 3'b000 : bus.car_on ? bus.car_rgb : bus.bg_rgb;
  end
  // syncs and colour trail the counters by one pixel so they stay mutually aligned
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else if (tick) begin
      hsync_q <= ~hs_raw;
      vsync_q <= ~vs_raw;
      rgb_q   <= rgb_next;
    end
  assign bus.pixel_x     = x;
  assign bus.pixel_y     = y;
  assign bus.pixel_tick  = tick;
  assign bus.video_on    = video;
  assign bus.frame_start = tick && (x == '0) && (y == '0);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.rgb_out     = rgb_q;
endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: scoreboarded directed checks on a reduced 35x19 raster
module tb_vga_scan_generator;
  localparam int XP = 0, YP = 1, TK = 2, VO = 3, FS = 4, HS = 5, VS = 6, RGB = 7;
  typedef struct {
    int ph;
    int e;
    int sig;
    int exp;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int edge_cnt = 0;
  int phase = 0;
  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  rec_t mr;
  int act;
  string nm[8] = '{"pixel_x", "pixel_y", "pixel_tick", "video_on", "frame_start", "hsync", "vsync", "rgb_out"};
  vga_scan_if bus();
  vga_scan_generator #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(10), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.car_on  = (bus.pixel_x >= 10'd8 && bus.pixel_x < 10'd12) || bus.pixel_x == 10'd25;
  assign bus.car_rgb = 3'b101;
  assign bus.bg_rgb  = 3'b010;
  always @(posedge clk or posedge reset)
    if (reset) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;
  function automatic int get(input int s);
    case (s)
      XP:      return int'(bus.pixel_x);
      YP:      return int'(bus.pixel_y);
      TK:      return int'(bus.pixel_tick);
      VO:      return int'(bus.video_on);
      FS:      return int'(bus.frame_start);
      HS:      return int'(bus.hsync);
      VS:      return int'(bus.vsync);
      default: return int'(bus.rgb_out);
    endcase
  endfunction
  task automatic push(input int ph, input int e, input int sig, input int exp);
    sb.push_back('{ph, e, sig, exp});
  endtask
  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s during reset: got %0d, expected %0d", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0 && (sb[0].ph < phase || (sb[0].ph == phase && sb[0].e <= edge_cnt))) begin
      mr = sb.pop_front();
      act = get(mr.sig);
      checks++;
      if (mr.ph != phase || mr.e != edge_cnt || act != mr.exp) begin
        errors++;
        $display("FAIL %s phase %0d edge %0d (seen at edge %0d): got %0d, expected %0d",
                 nm[mr.sig], mr.ph, mr.e, edge_cnt, act, mr.exp);
      end
    end
  end
  initial begin
    foreach (nm[i]) if (i != VO) push(0, 0, i, (i == HS || i == VS) ? 1 : 0);
    push(0, 1, TK, 1); push(0, 1, FS, 1); push(0, 1, XP, 0); push(0, 1, YP, 0);
    push(0, 2, TK, 0); push(0, 2, FS, 0); push(0, 2, XP, 1);
    push(0, 39, VO, 1); push(0, 40, VO, 0);
    push(0, 49, HS, 1); push(0, 50, HS, 0); push(0, 61, HS, 0); push(0, 62, HS, 1);
    push(0, 68, XP, 34); push(0, 70, XP, 0); push(0, 70, YP, 1);
    push(0, 367, RGB, 3'b010); push(0, 368, RGB, 3'b101); push(0, 372, RGB, 3'b101);
    push(0, 382, RGB, 3'b010); push(0, 402, RGB, 3'b000); push(0, 862, RGB, 3'b000);
    push(0, 911, VS, 1); push(0, 912, VS, 0); push(0, 1051, VS, 0); push(0, 1052, VS, 1);
    push(0, 1328, XP, 34); push(0, 1328, YP, 18);
    push(0, 1330, XP, 0); push(0, 1330, YP, 0); push(0, 1330, FS, 0);
    push(0, 1331, FS, 1); push(0, 1332, FS, 0);
    push(0, 1500, XP, 15); push(0, 1500, YP, 2); push(0, 1500, RGB, 3'b010);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("frame_start", int'(bus.frame_start), 0);
    reset = 1'b0;
    for (int i = 0; i < 2000 && edge_cnt < 1500; i++) @(posedge clk);
    @(negedge clk);
    #1;
    phase = 1;
    foreach (nm[i]) push(1, 0, i, (i == HS || i == VS || i == VO) ? 1 : 0);
    push(1, 1, FS, 1); push(1, 1, XP, 0); push(1, 1, YP, 0);
    push(1, 2, FS, 0); push(1, 2, XP, 1);
    push(1, 50, HS, 0); push(1, 62, HS, 1);
    push(1, 1330, FS, 0); push(1, 1331, FS, 1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pixel_x", int'(bus.pixel_x), 0);
    chk("pixel_y", int'(bus.pixel_y), 0);
    chk("hsync", int'(bus.hsync), 1);
    chk("vsync", int'(bus.vsync), 1);
    chk("rgb_out", int'(bus.rgb_out), 0);
    reset = 1'b0;
    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      mr = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s phase %0d edge %0d: never reached, expected %0d", nm[mr.sig], mr.ph, mr.e, mr.exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_scan_generator.md
VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_DISPLAY, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-010 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-011 The block SHALL have port car_on, input, 1 bit: car sprite layer covers the current pixel.
REQ-012 The block SHALL have port car_rgb, input, 3 bits: car sprite colour for the current pixel.
REQ-013 The block SHALL have port bg_rgb, input, 3 bits: background (road) colour for the current pixel.
REQ-014 The block SHALL have port pixel_x, output, 10 bits: current horizontal count, 0..H_total-1.
REQ-015 The block SHALL have port pixel_y, output, 10 bits: current vertical count, 0..V_total-1.
REQ-016 The block SHALL have port pixel_tick, output, 1 bit: 25 MHz pixel enable, high every second clk.
REQ-017 The block SHALL have port video_on, output, 1 bit: high iff pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
REQ-018 The block SHALL have port frame_start, output, 1 bit: one-clk pulse at start of each frame.
REQ-019 The block SHALL have ports hsync and vsync, output, 1 bit each: active-low sync pulses, registered.
REQ-020 The block SHALL have port rgb_out, output, 3 bits: registered composited pixel colour.

Function
REQ-021 H_total SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_total SHALL be V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-022 A 1-bit divider register SHALL toggle every clk; pixel_tick SHALL equal that register's value.
REQ-023 On a clk edge with pixel_tick=1, pixel_x SHALL increment, wrapping H_total-1 -> 0; pixel_x SHALL hold otherwise.
REQ-024 pixel_y SHALL increment only on the edge where pixel_x wraps, wrapping V_total-1 -> 0; both counters wrapping together SHALL give (0,0).
REQ-025 pixel_x, pixel_y, video_on SHALL be driven combinationally from counter registers; sprite layers compute car_on/car_rgb/bg_rgb combinationally from them.
REQ-026 frame_start SHALL be high exactly when pixel_tick=1, pixel_x=0 and pixel_y=0: one clk per frame.
REQ-027 Raw hsync condition SHALL be H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC (656..751); raw vsync condition SHALL be 490 <= pixel_y < 492.
REQ-028 On each pixel_tick edge, hsync/vsync registers SHALL load the inverse of raw conditions for the current counts; latency one pixel, aligned with rgb_out.
REQ-029 On each pixel_tick edge, rgb_out SHALL load: video_on=0 -> 3'b000; else car_on=1 -> car_rgb; else bg_rgb (car has priority).
REQ-030 hsync, vsync, rgb_out SHALL hold between pixel_tick edges.

Reset
REQ-031 While reset=1 divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, rgb_out=0, frame_start=0, regardless of clk.
REQ-032 After reset deassertion, first clk edge SHALL set pixel_tick=1 (frame_start=1); second edge SHALL advance pixel_x to 1.
REQ-033 Reset asserted mid-frame SHALL immediately return all state to REQ-031 values; the next frame SHALL start from (0,0) with full timing.

Verification
REQ-034 Reset then release: pixel_x=pixel_y=0, hsync=vsync=1, rgb_out=0; frame_start high for exactly 1 clk on first edge, then every 840000 clk.
REQ-035 Line timing: hsync falls one pixel after pixel_x=656 observed, stays low 96 pixels (192 clk); line period 1600 clk; pixel_x reaches 799 then 0.
REQ-036 Frame timing: vsync low for exactly 2 lines (3200 clk) starting on line 490; pixel_y wraps 524 -> 0 together with pixel_x 799 -> 0.
REQ-037 Compositing at pixel (100,50): car_on=1,car_rgb=3'b101,bg_rgb=3'b010 -> rgb_out=3'b101 one pixel later; car_on=0 -> 3'b010; at pixel (700,50) -> 3'b000.
REQ-038 Assert reset at pixel (400,300) for 3 clk -> all outputs at reset values during assertion; after release counts restart at (0,0), frame_start pulses once.
